// File: rtl/spram_arb_pkg.sv
// Shared types for the SPRAM arbiter: default widths, FSM encoding and the
// request bundle presented by each requester.
package spram_arb_pkg;

  localparam int SPRAM_AW = 14;
  localparam int SPRAM_DW = 16;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    STANDBY = 2'd1,
    WAKE    = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                we;
    logic [SPRAM_AW-1:0] addr;
    logic [SPRAM_DW-1:0] wdata;
    logic [3:0]          wmask;
  } spram_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way picker: a lone requester always wins, on conflict the side named
// by prefer wins (round-robin or fixed priority depending on how prefer is driven).
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       prefer,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | ~prefer);
    grant[1] = valid[1] & (~valid[0] |  prefer);
  end

endmodule

// File: rtl/spram_arbiter.sv
// Two-requester arbiter/sequencer for an SB_SPRAM256KA with idle-driven standby.
// Define SPRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins conflicts).
//
// state   | meaning
// --------+------------------------------------------------------------
// ACTIVE  | grants allowed, idle counter running
// STANDBY | RAM in standby, no grants, any valid starts a wake
// WAKE    | standby released, one settle cycle before grants resume
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int AW          = SPRAM_AW,
  parameter int DW          = SPRAM_DW,
  parameter int IDLE_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic [3:0]    req0_wmask,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic [3:0]    req1_wmask,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic [3:0]    ram_maskwren,
  output logic          ram_wren,
  output logic          ram_cs,
  output logic          ram_standby,
  input  logic [DW-1:0] ram_dout
);

  localparam int CW   = (IDLE_CYCLES < 2) ? 1 : $clog2(IDLE_CYCLES);
  localparam int TC_I = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TC = CW'(TC_I);

  arb_state_t    state, state_nx;
  logic [CW-1:0] idle_cnt, idle_nx;
  logic [1:0]    valid, pick, grant;
  logic          prefer;
  logic          any_grant;
  spram_req_t    sel;
  logic          rd_pend, rd_owner;
  logic [DW-1:0] rdata0_q, rdata1_q;

  assign valid = {req1_valid, req0_valid};

`ifdef SPRAM_ARB_FIXED_PRIO_EN
  assign prefer = 1'b0;
`else
  // last_gnt = 1 after reset so requester 0 is preferred first
  logic last_gnt;
  assign prefer = ~last_gnt;

  always_ff @(posedge clk) begin
    if (rst)           last_gnt <= 1'b1;
    else if (grant[0]) last_gnt <= 1'b0;
    else if (grant[1]) last_gnt <= 1'b1;
  end
`endif

  rr_pick2 u_pick (
    .valid  (valid),
    .prefer (prefer),
    .grant  (pick)
  );

  assign grant      = (state == ACTIVE && !rst) ? pick : 2'b00;
  assign any_grant  = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    sel = '0;
    if (grant[1]) sel = '{we: req1_we, addr: req1_addr, wdata: req1_wdata, wmask: req1_wmask};
    else          sel = '{we: req0_we, addr: req0_addr, wdata: req0_wdata, wmask: req0_wmask};
  end

  assign ram_cs       = any_grant;
  assign ram_wren     = any_grant & sel.we;
  assign ram_addr     = any_grant ? sel.addr : '0;
  assign ram_din      = any_grant ? sel.wdata : '0;
  assign ram_maskwren = (any_grant & sel.we) ? sel.wmask : 4'b0000;
  assign ram_standby  = (state == STANDBY);

  always_comb begin
    state_nx = state;
    idle_nx  = idle_cnt;
    case (state)
      ACTIVE: begin
        if (|valid) begin
          idle_nx = '0;
        end else if (IDLE_CYCLES != 0 && idle_cnt == TC) begin
          state_nx = STANDBY;
          idle_nx  = '0;
        end else if (idle_cnt != '1) begin
          idle_nx = idle_cnt + 1'b1;
        end
      end
      STANDBY: if (|valid) state_nx = WAKE;
      WAKE:    state_nx = ACTIVE;
      default: state_nx = ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACTIVE;
      idle_cnt <= '0;
    end else begin
      state    <= state_nx;
      idle_cnt <= idle_nx;
    end
  end

  // Response path: RAM has one cycle of read latency, so one pending bit suffices
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= any_grant & ~sel.we;
      rd_owner <= grant[1];
    end
  end

  assign rsp0_valid = rd_pend & ~rd_owner & ~rst;
  assign rsp1_valid = rd_pend &  rd_owner & ~rst;
  assign rsp0_rdata = rsp0_valid ? ram_dout : rdata0_q;
  assign rsp1_rdata = rsp1_valid ? ram_dout : rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rsp0_valid) rdata0_q <= ram_dout;
      if (rsp1_valid) rdata1_q <= ram_dout;
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: behavioural SPRAM, response scoreboard, scenario tasks.
module tb_spram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [13:0] req0_addr = '0;
  logic [15:0] req0_wdata = '0;
  logic [3:0]  req0_wmask = '0;
  logic        req0_ready, rsp0_valid;
  logic [15:0] rsp0_rdata;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [13:0] req1_addr = '0;
  logic [15:0] req1_wdata = '0;
  logic [3:0]  req1_wmask = '0;
  logic        req1_ready, rsp1_valid;
  logic [15:0] rsp1_rdata;
  logic [13:0] ram_addr;
  logic [15:0] ram_din;
  logic [3:0]  ram_maskwren;
  logic        ram_wren, ram_cs, ram_standby;
  logic [15:0] ram_dout = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          port;
    logic [15:0] data;
    int          cyc;
  } rsp_t;
  rsp_t sb[$];

  logic [15:0] ref_mem [int];
  logic [15:0] mem [0:16383];

  spram_arbiter #(.IDLE_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_maskwren(ram_maskwren),
    .ram_wren(ram_wren), .ram_cs(ram_cs), .ram_standby(ram_standby),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SPRAM: nibble-masked write, registered read
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wren) begin
        for (int n = 0; n < 4; n++)
          if (ram_maskwren[n]) mem[ram_addr][n*4 +: 4] <= ram_din[n*4 +: 4];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  // Response monitor and one-hot ready check
  always @(negedge clk) begin
    rsp_t e;
    if (req0_ready || req1_ready) begin
      checks++;
      if (req0_ready && req1_ready) begin
        failures++;
        $display("FAIL ready_onehot: got ready0=%b ready1=%b, required at most one high", req0_ready, req1_ready);
      end
    end
    for (int p = 0; p < 2; p++) begin
      logic        v;
      logic [15:0] d;
      v = (p == 0) ? rsp0_valid : rsp1_valid;
      d = (p == 0) ? rsp0_rdata : rsp1_rdata;
      if (v) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: got rsp%0d_valid=1 data=%h at cycle %0d, required no response", p, d, cyc);
        end else begin
          e = sb.pop_front();
          if (e.port != p || e.data !== d || e.cyc != cyc) begin
            failures++;
            $display("FAIL rsp_match: got port=%0d data=%h cycle=%0d, required port=%0d data=%h cycle=%0d",
                     p, d, cyc, e.port, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic drive(input int p, input logic v, input logic we, input logic [13:0] a,
                       input logic [15:0] d, input logic [3:0] m);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_wmask = m;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_wmask = m;
    end
  endtask

  task automatic note_accept(input int p, input logic we, input logic [13:0] a,
                             input logic [15:0] d, input logic [3:0] m);
    logic [15:0] cur;
    rsp_t        e;
    if (we) begin
      cur = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
      for (int n = 0; n < 4; n++)
        if (m[n]) cur[n*4 +: 4] = d[n*4 +: 4];
      ref_mem[int'(a)] = cur;
    end else begin
      e.port = p;
      e.data = ref_mem[int'(a)];
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
  endtask

  // One transfer: hold valid until ready (bounded), check the RAM drive on the grant
  task automatic access(input int p, input logic we, input logic [13:0] a,
                        input logic [15:0] d, input logic [3:0] m);
    bit   done = 0;
    logic rdy;
    drive(p, 1'b1, we, a, d, m);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      rdy = (p == 0) ? req0_ready : req1_ready;
      if (rdy) begin
        done = 1;
        checks++;
        if ({ram_cs, ram_wren, ram_addr, ram_din, ram_maskwren} !== {1'b1, we, a, d, (we ? m : 4'h0)}) begin
          failures++;
          $display("FAIL ram_drive: got cs=%b wren=%b addr=%h din=%h mask=%b, required cs=1 wren=%b addr=%h din=%h mask=%b",
                   ram_cs, ram_wren, ram_addr, ram_din, ram_maskwren, we, a, d, (we ? m : 4'h0));
        end
        note_accept(p, we, a, d, m);
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no ready on port %0d in 20 cycles, required accept", p);
    end
    drive(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_cs, ram_wren, ram_standby,
         ram_addr, ram_din, ram_maskwren, rsp0_rdata, rsp1_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_values: got rdy=%b%b rsp=%b%b cs=%b wren=%b stby=%b addr=%h din=%h mask=%b rd0=%h rd1=%h, required all zero",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_cs, ram_wren, ram_standby,
               ram_addr, ram_din, ram_maskwren, rsp0_rdata, rsp1_rdata);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Entered in cycle 0 after reset release; idle counter expires after 8 idle cycles
  task automatic test_standby();
    logic exp_rdy [3];
    logic exp_sb  [3];
    exp_rdy = '{1'b0, 1'b0, 1'b1};
    exp_sb  = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (ram_standby !== 1'b0) begin
        failures++;
        $display("FAIL standby_early: got standby=%b in idle cycle %0d, required 0", ram_standby, k);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (ram_standby !== 1'b1) begin
      failures++;
      $display("FAIL standby_enter: got standby=%b in idle cycle 8, required 1", ram_standby);
    end
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 14'h0030, 16'h1234, 4'hF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (req1_ready !== exp_rdy[k] || ram_standby !== exp_sb[k]) begin
        failures++;
        $display("FAIL wake_seq: step %0d got ready1=%b standby=%b, required ready1=%b standby=%b",
                 k, req1_ready, ram_standby, exp_rdy[k], exp_sb[k]);
      end
      if (req1_ready) note_accept(1, 1'b1, 14'h0030, 16'h1234, 4'hF);
      @(posedge clk); #1;
    end
    drive(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_single_read();
    access(0, 1'b1, 14'h0010, 16'hBEEF, 4'hF);
    access(0, 1'b0, 14'h0010, 16'h0000, 4'h0);
    access(1, 1'b0, 14'h0030, 16'h0000, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp0_rdata !== 16'hBEEF || rsp1_rdata !== 16'h1234) begin
      failures++;
      $display("FAIL rdata_hold: got rd0=%h rd1=%h, required rd0=beef rd1=1234", rsp0_rdata, rsp1_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mask();
    access(0, 1'b1, 14'h0020, 16'hFFFF, 4'hF);
    access(1, 1'b1, 14'h0020, 16'h0000, 4'b0011);
    access(0, 1'b0, 14'h0020, 16'h0000, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp0_rdata !== 16'hFF00) begin
      failures++;
      $display("FAIL mask_read: got %h, required ff00", rsp0_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int got = 0;
    int g;
    int exp_g [4];
`ifdef SPRAM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{1, 0, 1, 0};
`endif
    access(0, 1'b1, 14'h0100, 16'hA0A0, 4'hF);
    access(1, 1'b1, 14'h0101, 16'h5151, 4'hF);
    access(0, 1'b0, 14'h0100, 16'h0000, 4'h0);
    drive(0, 1'b1, 1'b0, 14'h0100, 16'h0000, 4'h0);
    drive(1, 1'b1, 1'b0, 14'h0101, 16'h0000, 4'h0);
    for (int i = 0; i < 20 && got < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        g = req1_ready ? 1 : 0;
        checks++;
        if (g != exp_g[got]) begin
          failures++;
          $display("FAIL contention_grant: grant %0d got requester %0d, required %0d", got, g, exp_g[got]);
        end
        note_accept(g, 1'b0, (g == 0) ? 14'h0100 : 14'h0101, 16'h0000, 4'h0);
        got++;
      end
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    if (got < 4) begin
      checks++;
      failures++;
      $display("FAIL contention_timeout: got %0d grants, required 4", got);
    end
  endtask

  // Valid arrives in the very cycle the idle counter hits its terminal count
  task automatic test_expiry();
    access(0, 1'b1, 14'h0040, 16'hC3C3, 4'hF);
    repeat (7) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 14'h0040, 16'h0000, 4'h0);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || ram_standby !== 1'b0) begin
      failures++;
      $display("FAIL expiry_grant: got ready0=%b standby=%b, required ready0=1 standby=0", req0_ready, ram_standby);
    end
    if (req0_ready) note_accept(0, 1'b0, 14'h0040, 16'h0000, 4'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++;
    if (ram_standby !== 1'b0) begin
      failures++;
      $display("FAIL expiry_stay_active: got standby=%b, required 0", ram_standby);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    access(1, 1'b0, 14'h0030, 16'h0000, 4'h0);
    rst = 1'b1;
    sb.delete();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard: got rsp0_valid=%b rsp1_valid=%b, required 0", rsp0_valid, rsp1_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_cs, ram_wren, ram_standby,
         ram_addr, ram_din, ram_maskwren, rsp0_rdata, rsp1_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_mid_values: got rdy=%b%b rsp=%b%b cs=%b wren=%b stby=%b addr=%h din=%h mask=%b rd0=%h rd1=%h, required all zero",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_cs, ram_wren, ram_standby,
               ram_addr, ram_din, ram_maskwren, rsp0_rdata, rsp1_rdata);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_standby();
    test_single_read();
    test_mask();
    test_contention();
    test_expiry();
    test_reset_mid_read();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rsp_missing: got %0d outstanding responses, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required finish");
    $fatal(1, "watchdog");
  end

endmodule
